// File: rtl/regfile.sv
// Multi-ported register file: one synchronous write port, two combinational read ports.
// Optional same-cycle write-through forwarding to the read ports when REGFILE_WRITE_BYPASS_EN is defined.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_index,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_a_index,
    output logic [DATA_WIDTH-1:0] read_a_data,
    input  logic [ADDR_WIDTH-1:0] read_b_index,
    output logic [DATA_WIDTH-1:0] read_b_data,
    input  logic                  reset
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reset wins over a coincident write; the write is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[write_index] <= write_data;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic write_live;

    assign write_live = write_enable && !reset;

    always_comb begin
        read_a_data = regs[read_a_index];
        read_b_data = regs[read_b_index];
        if (write_live && (read_a_index == write_index)) begin
            read_a_data = write_data;
        end
        if (write_live && (read_b_index == write_index)) begin
            read_b_data = write_data;
        end
    end
`else
    always_comb begin
        read_a_data = regs[read_a_index];
        read_b_data = regs[read_b_index];
    end
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed plan steps followed by a randomized run
// against an array-based reference model.
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int NR = 4;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_index;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_a_index;
    logic [DW-1:0] read_a_data;
    logic [AW-1:0] read_b_index;
    logic [DW-1:0] read_b_data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model [NR];

    regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .write_enable (write_enable),
        .write_index  (write_index),
        .write_data   (write_data),
        .read_a_index (read_a_index),
        .read_a_data  (read_a_data),
        .read_b_index (read_b_index),
        .read_b_data  (read_b_data),
        .reset        (reset)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] idx);
        if (BYPASS && write_enable && !reset && idx == write_index)
            return write_data;
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_a"}, read_a_data, expect_read(read_a_index));
        check({tag, "_b"}, read_b_data, expect_read(read_b_index));
    endtask

    // Advance one rising edge and apply the register-file rules to the model.
    task automatic edge_update();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) model[i] = '0;
        end else if (write_enable) begin
            model[write_index] = write_data;
        end
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b1;
        write_index  = AW'($urandom_range(0, NR - 1));
        write_data   = 32'hFFFF_FFFF;
        read_a_index = '0;
        read_b_index = '0;
        for (int i = 0; i < NR; i++) model[i] = 'x;

        // Reset with a coincident write: everything reads 0 afterwards.
        edge_update();
        @(negedge clk);
        reset = 1'b0;
        write_enable = 1'b0;
        for (int i = 0; i < NR; i++) begin
            read_a_index = AW'(i);
            read_b_index = AW'(NR - 1 - i);
            #1;
            check("reset_clear_a", read_a_data, 32'h0);
            check("reset_clear_b", read_b_data, 32'h0);
        end

        // Sequential fill: index i gets value i.
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            write_enable = 1'b1;
            write_index  = AW'(i);
            write_data   = DW'(i);
            edge_update();
        end
        @(negedge clk);
        write_enable = 1'b0;
        for (int i = 0; i < NR; i++) begin
            read_a_index = AW'(i);
            #1;
            check("fill_sweep", read_a_data, DW'(i));
        end

        // Dual read, distinct then identical indices.
        read_a_index = 2'd3;
        read_b_index = 2'd1;
        #1;
        check("dual_a3", read_a_data, 32'd3);
        check("dual_b1", read_b_data, 32'd1);
        read_a_index = 2'd2;
        read_b_index = 2'd2;
        #1;
        check("same_a2", read_a_data, 32'd2);
        check("same_b2", read_b_data, 32'd2);

        // Write disable holds register 0.
        @(negedge clk);
        write_enable = 1'b0;
        write_index  = 2'd0;
        write_data   = 32'hDEAD_BEEF;
        read_a_index = 2'd0;
        for (int i = 0; i < 3; i++) edge_update();
        check("we_off_reg0", read_a_data, 32'h0);

        // Overwrite index 2, others isolated.
        @(negedge clk);
        write_enable = 1'b1;
        write_index  = 2'd2;
        write_data   = 32'hA5A5_A5A5;
        edge_update();
        @(negedge clk);
        write_enable = 1'b0;
        for (int i = 0; i < NR; i++) begin
            read_b_index = AW'(i);
            #1;
            check("overwrite_iso", read_b_data, (i == 2) ? 32'hA5A5_A5A5 : DW'(i));
        end

        // Read-during-write on index 1.
        @(negedge clk);
        write_enable = 1'b1;
        write_index  = 2'd1;
        write_data   = 32'h1234_5678;
        read_a_index = 2'd1;
        #1;
        check("rdw_before", read_a_data, BYPASS ? 32'h1234_5678 : 32'd1);
        edge_update();
        check("rdw_after", read_a_data, 32'h1234_5678);

        // Randomized traffic, checked before and after each edge.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 31) == 0);
            write_enable = $urandom_range(0, 1) == 1;
            write_index  = AW'($urandom_range(0, NR - 1));
            write_data   = $urandom;
            read_a_index = AW'($urandom_range(0, NR - 1));
            read_b_index = ($urandom_range(0, 3) == 0) ? write_index : AW'($urandom_range(0, NR - 1));
            #1;
            check_ports("rand_pre");
            edge_update();
            check_ports("rand_post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
